lane_src: RTL

- Transmit-side counterpart of the three-lane narrowing sink: lane_src drives the in1/in2/in3 lane set that the sink consumes.
- A writer loads one frame of bytes into an internal byte buffer (8-bit entries, depth 2*P1, the same shape as the sink's byte array).
- The block then replays the frame beat-by-beat onto the three lanes with a valid/ready handshake.
- It sits between a byte producer and the lane sink, one frame in flight at a time.

---
 rtl/lane_src_pkg.sv | 24 ++
 rtl/lane_src_buf.sv | 27 ++
 rtl/lane_src.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lane_src_pkg.sv
// Shared types and helpers for the lane_src frame replayer: FSM states,
// the byte width, counter sizing and the beat record presented on the lanes.
package lane_src_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [3:0]        idx;
        logic              last;
    } beat_t;

    // One extra bit so a count can reach DEPTH itself without wrapping.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lane_src_buf.sv
// Frame byte store: DEPTH x 8 registers, one synchronous write port and one
// combinational read port. Contents are deliberately left unreset.
module lane_src_buf
    import lane_src_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lane_src.sv
// Loads one frame of bytes from a writer, then replays it beat-by-beat onto
// the three narrowing lanes (low bits, resized byte, beat index).
module lane_src
    import lane_src_pkg::*;
#(
    parameter int P1 = 4,
    parameter int P2 = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [7:0]    wr_data,
    input  logic          wr_last,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [P1-1:0] out1,
    output logic [P2-1:0] out2,
    output logic [3:0]    out3,
    output logic          out_last,
    output logic          busy
);

    localparam int DEPTH = 2 * P1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    if (P1 < 1 || P1 > BYTE_W) begin : g_p1_range
        $error("lane_src: P1 must lie in 1..8");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] rd_byte;
    logic              wr_fire;
    logic              rd_fire;
    logic              close_frame;
    beat_t             beat;

    // wr_ready is gated by rst_n so it reads 0 throughout reset.
    assign wr_ready    = rst_n && (state_q == IDLE || state_q == LOAD);
    assign out_valid   = (state_q == DRAIN);
    assign busy        = (state_q != IDLE);
    assign wr_fire     = wr_valid && wr_ready && !flush;
    assign rd_fire     = out_valid && out_ready;
    assign close_frame = wr_fire && (wr_last || wr_cnt_q == LAST_IDX);

    lane_src_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (wr_fire),
        .waddr_i (AW'(wr_cnt_q)),
        .wdata_i (wr_data),
        .raddr_i (AW'(rd_cnt_q)),
        .rdata_o (rd_byte)
    );

    assign beat.data = rd_byte;
    assign beat.idx  = 4'(rd_cnt_q);
    assign beat.last = (rd_cnt_q == len_q - CNT_ONE);

    // Lanes read zero whenever no beat is on offer.
    assign out1     = out_valid ? P1'(beat.data) : '0;
    assign out2     = out_valid ? P2'(beat.data) : '0;
    assign out3     = out_valid ? beat.idx : '0;
    assign out_last = out_valid && beat.last;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        len_d    = len_q;
        if (flush) begin
            state_d  = IDLE;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            len_d    = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (wr_fire) begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                        state_d  = LOAD;
                        if (close_frame) begin
                            state_d = DRAIN;
                            len_d   = wr_cnt_q + CNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_fire) begin
                        if (beat.last) begin
                            state_d  = IDLE;
                            wr_cnt_d = '0;
                            rd_cnt_d = '0;
                            len_d    = '0;
                        end else begin
                            rd_cnt_d = rd_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            len_q    <= len_d;
        end
    end

endmodule
